mips_instr_encoder: RTL and testbench

Sequential instruction encoder that assembles MIPS R/I/J-format words from field-level commands and writes them into instruction memory at consecutive word addresses. It is the producing end of the instruction path whose consuming end is the opcode/funct control decode. It is used by test harnesses and the boot loader to build programs in instruction memory without hand-packed hex. Commands arrive over a valid/ready handshake, and memory writes are held until acknowledged.

---
 rtl/mips_instr_encoder.sv | 161 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// MIPS R/I/J instruction encoder: packs field-level commands into words and writes them to imem.
// Latency: command accepted at n -> imem_we at n+1; last ack at m -> done at m+1, idle at m+2.
// Backpressure: cmd_ready only in ACCEPT; imem_we/addr/wdata held until imem_ack.
// Optional: MIPS_ENC_CHECK_EN rejects reserved formats and R words with nonzero opcode.
module mips_instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_fmt,
    input  logic [5:0]        cmd_opcode,
    input  logic [5:0]        cmd_funct,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    // Count value meaning every word of memory has been written once.
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic [ADDR_W:0]   count_inc;
    logic              cmd_bad;

    assign count_inc = count_q + CNT_ONE;

    // Pack the command fields into an instruction word; reserved format falls back to R.
    always_comb begin
        enc_word = {cmd_opcode, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
        case (cmd_fmt)
            2'd1:    enc_word = {cmd_opcode, cmd_rs, cmd_rt, cmd_imm};
            2'd2:    enc_word = {cmd_opcode, cmd_target};
            default: enc_word = {cmd_opcode, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
        endcase
    end

`ifdef MIPS_ENC_CHECK_EN
    // Malformed commands are swallowed without a write and flagged in err.
    assign cmd_bad = (cmd_fmt == 2'd3) || ((cmd_fmt == 2'd0) && (cmd_opcode != 6'd0));
`else
    assign cmd_bad = 1'b0;
`endif

    // Next-state and datapath updates for the load sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                        if (cmd_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        wdata_d = enc_word;
                        last_d  = cmd_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (imem_ack) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_inc;
                    if (count_inc == CNT_FULL) begin
                        // Memory is full: stop before the address wraps onto word 0 of this load.
                        state_d = S_DONE;
                        if (!last_q) begin
                            err_d = 1'b1;
                        end
                    end else if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = (state_q == S_ACCEPT);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: default-width instance plus a 4-bit-address instance.
// Latency checks: start->ready at n+1, accept->we at n+1, last ack->done at m+1, idle at m+2.
// Backpressure checks: write held through delayed acks, no command taken while writing.
module tb_mips_instr_encoder;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic        cmd_valid;
    logic [1:0]  cmd_fmt;
    logic [5:0]  cmd_opcode;
    logic [5:0]  cmd_funct;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_shamt;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        cmd_last;
    logic        imem_ack;

    logic        a_ready, a_we, a_busy, a_done, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_cnt;
    logic        b_ready, b_we, b_busy, b_done, b_err;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [4:0]  b_cnt;

    logic        sel = 1'b0;
    logic        o_ready, o_we, o_busy, o_done, o_err;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;
    logic [10:0] o_cnt;

    int total = 0;
    int bad   = 0;
    vec_t vecs [8];
    vec_t v_bad;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .cmd_valid(cmd_valid), .cmd_ready(a_ready), .cmd_fmt(cmd_fmt),
        .cmd_opcode(cmd_opcode), .cmd_funct(cmd_funct), .cmd_rs(cmd_rs),
        .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .imem_ack(imem_ack), .busy(a_busy), .done(a_done), .count(a_cnt), .err(a_err)
    );

    mips_instr_encoder #(.ADDR_W(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[3:0]),
        .cmd_valid(cmd_valid), .cmd_ready(b_ready), .cmd_fmt(cmd_fmt),
        .cmd_opcode(cmd_opcode), .cmd_funct(cmd_funct), .cmd_rs(cmd_rs),
        .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .imem_ack(imem_ack), .busy(b_busy), .done(b_done), .count(b_cnt), .err(b_err)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_we    = sel ? b_we    : a_we;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_err   = sel ? b_err   : a_err;
    assign o_addr  = sel ? {6'b0, b_addr} : a_addr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    assign o_cnt   = sel ? {6'b0, b_cnt} : a_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_ready", 64'(o_ready), 64'd1);
    endtask

    task automatic drive(input vec_t v, input logic last);
        cmd_fmt    = v.fmt;
        cmd_opcode = v.op;
        cmd_rs     = v.rs;
        cmd_rt     = v.rt;
        cmd_rd     = v.rd;
        cmd_shamt  = v.sh;
        cmd_funct  = v.fn;
        cmd_imm    = v.imm;
        cmd_target = v.tgt;
        cmd_last   = last;
    endtask

    // Present one command and hold it until the edge that takes it.
    task automatic issue(input vec_t v, input logic last);
        int n;
        drive(v, last);
        cmd_valid = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(o_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Check the pending write, stall it for 'delay' cycles, then acknowledge it.
    task automatic ack_write(input logic [9:0] addr, input logic [31:0] data,
                             input int delay, input logic [10:0] cnt_after);
        chk("we_on", 64'(o_we), 64'd1);
        chk("waddr", 64'(o_addr), 64'(addr));
        chk("wdata", 64'(o_wdata), 64'(data));
        for (int d = 0; d < delay; d++) begin
            drive(vecs[7], 1'b1);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk("stall_we", 64'(o_we), 64'd1);
            chk("stall_ready", 64'(o_ready), 64'd0);
            chk("stall_addr", 64'(o_addr), 64'(addr));
            chk("stall_data", 64'(o_wdata), 64'(data));
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("count_after_ack", 64'(o_cnt), 64'(cnt_after));
    endtask

    task automatic finish_load(input logic [10:0] cnt, input logic e);
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("done_we", 64'(o_we), 64'd0);
        chk("done_count", 64'(o_cnt), 64'(cnt));
        chk("done_err", 64'(o_err), 64'(e));
        tick();
        chk("done_clear", 64'(o_done), 64'd0);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("idle_count", 64'(o_cnt), 64'(cnt));
    endtask

    task automatic chk_reset_outputs;
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_addr", 64'(o_addr), 64'd0);
        chk("rst_wdata", 64'(o_wdata), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_count", 64'(o_cnt), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           fmt   op     rs     rt     rd     sh     fn     imm        tgt           expected
        vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hBEEF, 26'h3FFFFFF, 32'h00221820}; // add
        vecs[1] = '{2'd1, 6'h08, 5'd0,  5'd2,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 32'h20020005}; // addi
        vecs[2] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010}; // j
        vecs[3] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd8,  5'd4,  6'h00, 16'h0000, 26'h0000000, 32'h00094100}; // sll
        vecs[4] = '{2'd1, 6'h23, 5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 32'h8FFFFFFF};
        vecs[5] = '{2'd2, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF}; // jal
        vecs[6] = '{2'd1, 6'h0D, 5'd5,  5'd6,  5'd31, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'h34A61234}; // ori
        vecs[7] = '{2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h2AAAAAA, 32'h0AAAAAAA};
        v_bad   = '{2'd3, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 32'h00221820};

        rst = 1'b1; start = 1'b0; base_addr = '0; cmd_valid = 1'b0; imem_ack = 1'b0;
        drive(vecs[0], 1'b0);
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();

        // Single add word at 0x010, with a stray ack while waiting for the command.
        do_start(10'h010);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("stray_ack_count", 64'(o_cnt), 64'd0);
        chk("stray_ack_ready", 64'(o_ready), 64'd1);
        issue(vecs[0], 1'b1);
        ack_write(10'h010, 32'h00221820, 0, 11'd1);
        finish_load(11'd1, 1'b0);

        // Encoding table: one single-word load per vector.
        for (int i = 0; i < 8; i++) begin
            do_start(10'h100 + 10'(i));
            issue(vecs[i], 1'b1);
            ack_write(10'h100 + 10'(i), vecs[i].exp, 0, 11'd1);
            finish_load(11'd1, 1'b0);
        end

        // Three-word program, every ack delayed 3 cycles; a mid-load start is ignored.
        do_start(10'h000);
        issue(vecs[1], 1'b0);
        ack_write(10'h000, 32'h20020005, 3, 11'd1);
        base_addr = 10'h3FF;
        start = 1'b1;
        issue(vecs[0], 1'b0);
        start = 1'b0;
        ack_write(10'h001, 32'h00221820, 3, 11'd2);
        issue(vecs[2], 1'b1);
        ack_write(10'h002, 32'h08000010, 3, 11'd3);
        finish_load(11'd3, 1'b0);

        // 4-bit instance: load starting at 0xF wraps to 0 without error.
        sel = 1'b1;
        do_start(10'h00F);
        issue(vecs[1], 1'b0);
        ack_write(10'h00F, 32'h20020005, 0, 11'd1);
        issue(vecs[0], 1'b1);
        ack_write(10'h000, 32'h00221820, 0, 11'd2);
        finish_load(11'd2, 1'b0);

        // 4-bit instance: 16 writes with no last fills memory, then err and done.
        do_start(10'h003);
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i % 8], 1'b0);
            ack_write(10'((3 + i) % 16), vecs[i % 8].exp, 0, 11'(i + 1));
        end
        chk("ovf_done", 64'(o_done), 64'd1);
        chk("ovf_err", 64'(o_err), 64'd1);
        chk("ovf_count", 64'(o_cnt), 64'd16);
        drive(vecs[3], 1'b0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_no_accept", 64'(o_ready), 64'd0);
            chk("ovf_no_write", 64'(o_we), 64'd0);
            chk("ovf_idle", 64'(o_busy), 64'd0);
        end
        cmd_valid = 1'b0;
        chk("ovf_err_sticky", 64'(o_err), 64'd1);
        chk("ovf_count_hold", 64'(o_cnt), 64'd16);
        do_start(10'h000);
        chk("start_clears_err", 64'(o_err), 64'd0);
        chk("start_clears_count", 64'(o_cnt), 64'd0);
        sel = 1'b0;

        // Reset while a write is pending, then a normal load.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_start(10'h050);
        issue(vecs[6], 1'b0);
        chk("pre_rst_we", 64'(o_we), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        tick();
        chk("post_rst_we", 64'(o_we), 64'd0);
        do_start(10'h020);
        issue(vecs[0], 1'b1);
        ack_write(10'h020, 32'h00221820, 0, 11'd1);
        finish_load(11'd1, 1'b0);

        // Reserved format: rejected with the check build, encoded as R otherwise.
        do_start(10'h040);
        issue(v_bad, 1'b0);
`ifdef MIPS_ENC_CHECK_EN
        chk("bad_no_we", 64'(o_we), 64'd0);
        chk("bad_err", 64'(o_err), 64'd1);
        chk("bad_back_accept", 64'(o_ready), 64'd1);
        chk("bad_count", 64'(o_cnt), 64'd0);
        issue(vecs[1], 1'b1);
        ack_write(10'h040, 32'h20020005, 0, 11'd1);
        finish_load(11'd1, 1'b1);
`else
        ack_write(10'h040, 32'h00221820, 0, 11'd1);
        chk("fmt3_err", 64'(o_err), 64'd0);
        issue(vecs[1], 1'b1);
        ack_write(10'h041, 32'h20020005, 0, 11'd2);
        finish_load(11'd2, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
